// File: rtl/tmr_vote_monitor.sv
// Bitwise TMR majority voter with per-replica fault tracking and a valid/ready fault event port.
// Latency: vote 1 cycle; fault event offered 1 cycle after the fault flag. Events are held stable until evt_ready.
// Backpressure: faults arriving while an event waits are queued as pending bits and served in index order.
module tmr_vote_monitor #(
    parameter int WIDTH        = 13,
    parameter int CNT_W        = 4,
    parameter int FAULT_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] rep_a,
    input  logic [WIDTH-1:0] rep_b,
    input  logic [WIDTH-1:0] rep_c,
    input  logic             clr_faults,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       mismatch_mask,
    output logic [2:0]       fault_mask,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_replica,
    output logic [CNT_W-1:0] evt_seq
);

    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_SEND   = 1'b1;
    localparam logic [CNT_W-1:0] THRESH    = CNT_W'(FAULT_THRESH);
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(FAULT_THRESH - 1);

    logic [WIDTH-1:0] maj;
    logic [2:0]       mism;
    logic [2:0]       trig;
    logic [2:0]       pend;
    logic [2:0]       pend_clr;
    logic [CNT_W-1:0] cnt [3];
    logic [0:0]       state;
    logic [1:0]       low_idx;
    logic             accept;

    assign maj  = (rep_a & rep_b) | (rep_a & rep_c) | (rep_b & rep_c);
    assign mism = {rep_c != maj, rep_b != maj, rep_a != maj};

    // A fault fires only on the step into the threshold, so a saturated streak stays silent.
    always_comb begin
        trig = '0;
        for (int i = 0; i < 3; i++) begin
            trig[i] = in_valid && mism[i] && (cnt[i] == THRESH_M1);
        end
    end

    assign low_idx   = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
    assign accept    = (state == ST_SEND) && evt_ready;
    assign pend_clr  = accept ? (3'b001 << evt_replica) : 3'b000;
    assign evt_valid = (state == ST_SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            mismatch_mask <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data      <= maj;
                mismatch_mask <= mism;
            end else begin
                mismatch_mask <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clr_faults) begin
                    cnt[i] <= '0;
                end else if (in_valid) begin
                    if (!mism[i])
                        cnt[i] <= '0;
                    else if (cnt[i] != THRESH)
                        cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pend        <= '0;
            fault_mask  <= '0;
            evt_replica <= '0;
            evt_seq     <= '0;
        end else if (clr_faults) begin
            state      <= ST_IDLE;
            pend       <= '0;
            fault_mask <= '0;
        end else begin
            // A new trigger on the replica being accepted wins over the clear.
            pend       <= (pend & ~pend_clr) | trig;
            fault_mask <= fault_mask | trig;
            case (state)
                ST_IDLE: begin
                    if (pend != 3'b000) begin
                        evt_replica <= low_idx;
                        state       <= ST_SEND;
                    end
                end
                default: begin
                    if (evt_ready) begin
                        evt_seq <= evt_seq + CNT_W'(1);
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: directed scenarios plus randomized traffic against a behavioural model.
module tb_tmr_vote_monitor;

    localparam int W  = 13;
    localparam int CW = 4;
    localparam int TH = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  rep_a = '0, rep_b = '0, rep_c = '0;
    logic          clr_faults = 1'b0;
    logic          evt_ready = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [2:0]    mismatch_mask;
    logic [2:0]    fault_mask;
    logic          evt_valid;
    logic [1:0]    evt_replica;
    logic [CW-1:0] evt_seq;

    tmr_vote_monitor #(.WIDTH(W), .CNT_W(CW), .FAULT_THRESH(TH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .rep_a(rep_a), .rep_b(rep_b), .rep_c(rep_c),
        .clr_faults(clr_faults),
        .out_valid(out_valid), .out_data(out_data), .mismatch_mask(mismatch_mask),
        .fault_mask(fault_mask), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_replica(evt_replica), .evt_seq(evt_seq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    bit         m_ov;
    bit [W-1:0] m_data;
    bit [2:0]   m_mm;
    int         m_streak [3];
    bit [2:0]   m_fault;
    bit [2:0]   m_pend;
    bit         m_off;
    int         m_idx;
    int         m_seq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [W-1:0] vote(input bit [W-1:0] a, b, c);
        bit [W-1:0] r;
        for (int n = 0; n < W; n++) begin
            int ones;
            ones = int'(a[n]) + int'(b[n]) + int'(c[n]);
            r[n] = (ones >= 2);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ov = 0; m_data = '0; m_mm = '0; m_fault = '0; m_pend = '0;
        m_off = 0; m_idx = 0; m_seq = 0;
        for (int i = 0; i < 3; i++) m_streak[i] = 0;
    endtask

    task automatic model_edge();
        bit [W-1:0] maj;
        bit [W-1:0] reps [3];
        bit [2:0]   trig;
        reps[0] = rep_a; reps[1] = rep_b; reps[2] = rep_c;
        maj  = vote(rep_a, rep_b, rep_c);
        trig = '0;
        m_ov = in_valid;
        m_mm = '0;
        if (in_valid) begin
            m_data = maj;
            for (int i = 0; i < 3; i++) m_mm[i] = (reps[i] != maj);
        end
        if (clr_faults) begin
            for (int i = 0; i < 3; i++) m_streak[i] = 0;
            m_fault = '0; m_pend = '0; m_off = 0;
        end else begin
            if (in_valid) begin
                for (int i = 0; i < 3; i++) begin
                    if (reps[i] == maj) m_streak[i] = 0;
                    else if (m_streak[i] < TH) begin
                        m_streak[i]++;
                        if (m_streak[i] == TH) trig[i] = 1;
                    end
                end
            end
            if (m_off) begin
                if (evt_ready) begin
                    m_pend[m_idx] = 0;
                    m_seq = (m_seq + 1) % (1 << CW);
                    m_off = 0;
                end
            end else if (m_pend != 0) begin
                for (int i = 2; i >= 0; i--) if (m_pend[i]) m_idx = i;
                m_off = 1;
            end
            m_pend  = m_pend | trig;
            m_fault = m_fault | trig;
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data", 32'(out_data), 32'(m_data));
        check("mismatch_mask", 32'(mismatch_mask), 32'(m_mm));
        check("fault_mask", 32'(fault_mask), 32'(m_fault));
        check("evt_valid", 32'(evt_valid), 32'(m_off));
        check("evt_replica", 32'(evt_replica), 32'(m_idx));
        check("evt_seq", 32'(evt_seq), 32'(m_seq));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] a, b, c, input logic clr, rdy);
        in_valid = iv; rep_a = a; rep_b = b; rep_c = c;
        clr_faults = clr; evt_ready = rdy;
        cycle();
    endtask

    initial begin
        bit [W-1:0] base;
        int         bad;

        // Reset state
        model_reset();
        #2;
        compare_all();
        #10;
        rst_n = 1'b1;

        // T1: unanimous sample, then hold
        drive(1, 13'h1ABC, 13'h1ABC, 13'h1ABC, 0, 0);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h1ABC);
        check("t1_mask", 32'(mismatch_mask), 32'd0);
        drive(0, 13'h0, 13'h0, 13'h0, 0, 0);
        check("t1_valid_low", 32'(out_valid), 32'd0);
        check("t1_data_hold", 32'(out_data), 32'h1ABC);

        // T2: single outlier, then all three differ
        drive(1, 13'h0F0F, 13'h0F0F, 13'h1234, 0, 0);
        check("t2_data", 32'(out_data), 32'h0F0F);
        check("t2_mask", 32'(mismatch_mask), 32'h4);
        drive(1, 13'h0001, 13'h0002, 13'h0004, 0, 0);
        check("t2_data3", 32'(out_data), 32'h0);
        check("t2_mask3", 32'(mismatch_mask), 32'h7);
        drive(1, 13'h0, 13'h0, 13'h0, 0, 1);

        // T3: c wrong three samples with consumer always ready
        for (int k = 0; k < 3; k++) drive(1, 13'h0055, 13'h0055, 13'h0AA0, 0, 1);
        check("t3_fault", 32'(fault_mask), 32'h4);
        check("t3_noevt_yet", 32'(evt_valid), 32'd0);
        drive(0, 13'h0, 13'h0, 13'h0, 0, 1);
        check("t3_evt_valid", 32'(evt_valid), 32'd1);
        check("t3_evt_rep", 32'(evt_replica), 32'd2);
        check("t3_evt_seq", 32'(evt_seq), 32'd0);
        drive(0, 13'h0, 13'h0, 13'h0, 0, 1);
        check("t3_accepted", 32'(evt_valid), 32'd0);
        check("t3_seq_after", 32'(evt_seq), 32'd1);

        // T4: broken streak gives no fault; gaps inside a streak still count
        drive(0, 13'h0, 13'h0, 13'h0, 1, 1);
        drive(1, 13'h0011, 13'h0011, 13'h0100, 0, 1);
        drive(1, 13'h0011, 13'h0011, 13'h0100, 0, 1);
        drive(1, 13'h0011, 13'h0011, 13'h0011, 0, 1);
        drive(1, 13'h0011, 13'h0011, 13'h0100, 0, 1);
        drive(1, 13'h0011, 13'h0011, 13'h0100, 0, 1);
        drive(1, 13'h0011, 13'h0011, 13'h0011, 0, 1);
        check("t4_no_fault", 32'(fault_mask), 32'd0);
        drive(1, 13'h0011, 13'h0011, 13'h0100, 0, 1);
        drive(0, 13'h0, 13'h0, 13'h0, 0, 1);
        drive(1, 13'h0011, 13'h0011, 13'h0100, 0, 1);
        drive(0, 13'h0, 13'h0, 13'h0, 0, 1);
        drive(0, 13'h0, 13'h0, 13'h0, 0, 1);
        drive(1, 13'h0011, 13'h0011, 13'h0100, 0, 1);
        check("t4_gap_fault", 32'(fault_mask), 32'h4);
        for (int k = 0; k < 3; k++) drive(0, 13'h0, 13'h0, 13'h0, 0, 1);
        check("t4_seq", 32'(evt_seq), 32'd2);

        // T5: backpressured events served in index order
        drive(0, 13'h0, 13'h0, 13'h0, 1, 0);
        for (int k = 0; k < 3; k++) drive(1, 13'h1F00, 13'h00F0, 13'h00F0, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, 13'h00F0, 13'h00F0, 13'h1F00, 0, 0);
        check("t5_faults", 32'(fault_mask), 32'h5);
        for (int k = 0; k < 10; k++) begin
            drive(0, 13'h0, 13'h0, 13'h0, 0, 0);
            check("t5_hold_valid", 32'(evt_valid), 32'd1);
            check("t5_hold_rep", 32'(evt_replica), 32'd0);
        end
        drive(0, 13'h0, 13'h0, 13'h0, 0, 1);
        check("t5_gap", 32'(evt_valid), 32'd0);
        drive(0, 13'h0, 13'h0, 13'h0, 0, 0);
        check("t5_second_valid", 32'(evt_valid), 32'd1);
        check("t5_second_rep", 32'(evt_replica), 32'd2);
        check("t5_second_seq", 32'(evt_seq), 32'd3);

        // T6: clear aborts the offer but keeps evt_seq; async reset mid-streak
        drive(0, 13'h0, 13'h0, 13'h0, 1, 0);
        check("t6_clr_evt", 32'(evt_valid), 32'd0);
        check("t6_clr_fault", 32'(fault_mask), 32'd0);
        check("t6_clr_seq", 32'(evt_seq), 32'd3);
        drive(1, 13'h0700, 13'h0700, 13'h0007, 0, 1);
        drive(1, 13'h0700, 13'h0700, 13'h0007, 0, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("t6_rst_data", 32'(out_data), 32'd0);
        #4;
        rst_n = 1'b1;
        drive(1, 13'h0700, 13'h0700, 13'h0007, 0, 1);
        check("t6_streak_lost", 32'(fault_mask), 32'd0);

        // Randomized traffic against the model
        bad = 3;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) bad = $urandom_range(0, 3);
            base     = W'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            rep_a = base; rep_b = base; rep_c = base;
            if (bad < 3 && $urandom_range(0, 3) != 0) begin
                case (bad)
                    0: rep_a = base ^ W'($urandom_range(1, 8191));
                    1: rep_b = base ^ W'($urandom_range(1, 8191));
                    default: rep_c = base ^ W'($urandom_range(1, 8191));
                endcase
            end
            if ($urandom_range(0, 15) == 0) rep_b = rep_b ^ W'($urandom_range(1, 8191));
            clr_faults = ($urandom_range(0, 63) == 0);
            evt_ready  = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
